// File: rtl/calc_pkg.sv
// calc_pkg: shared types for the accumulator calculator.
// Opcodes, FSM states and the flag-source selector per opcode.
package calc_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_OR   = 3'b010,
    OP_EQ   = 3'b011,
    OP_AND  = 3'b100,
    OP_XOR  = 3'b101,
    OP_MUL  = 3'b110,
    OP_LOAD = 3'b111
  } calc_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    WAIT = 2'd2
  } calc_state_t;

  typedef enum logic [2:0] {
    FLG_ZERO   = 3'd0,
    FLG_CARRY  = 3'd1,
    FLG_BORROW = 3'd2,
    FLG_EQUAL  = 3'd3,
    FLG_HIGH   = 3'd4
  } calc_flag_t;

  function automatic calc_flag_t flag_src(
    input calc_op_t op
  );
    calc_flag_t f;
    f = FLG_ZERO;
    case (op)
      OP_ADD:  f = FLG_CARRY;
      OP_SUB:  f = FLG_BORROW;
      OP_EQ:   f = FLG_EQUAL;
      OP_MUL:  f = FLG_HIGH;
      default: f = FLG_ZERO;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/calc_mul_seq.sv
// calc_mul_seq: WIDTH-step shift-add multiplier.
// Ports: clk, rst, ena, start, a, b -> product (2*WIDTH), done.
module calc_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic               done
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;
  logic               run_q;

  // The start edge already performs step one, so after
  // WIDTH-1 further steps the product is complete and done
  // is held until the consumer takes it on an enabled edge.
  assign done    = run_q && (cnt_q == CW'(WIDTH));
  assign product = acc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else if (ena) begin
      if (start) begin
        mcand_q  <= {{WIDTH{1'b0}}, a} << 1;
        mplier_q <= b >> 1;
        acc_q    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
        cnt_q    <= CW'(1);
        run_q    <= 1'b1;
      end else if (run_q) begin
        if (done) begin
          run_q <= 1'b0;
        end else begin
          if (mplier_q[0]) begin
            acc_q <= acc_q + mcand_q;
          end
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/calc_core.sv
// calc_core: DEPTH x WIDTH accumulator file with an 8-op ALU.
// Ports: clk, rst, ena, NumIn, OpIn, RegSel, Enter -> NumOut, Flag, Busy, Done.
module calc_core
  import calc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic [WIDTH-1:0]         NumIn,
  input  logic [2:0]               OpIn,
  input  logic [$clog2(DEPTH)-1:0] RegSel,
  input  logic                     Enter,
  output logic [WIDTH-1:0]         NumOut,
  output logic                     Flag,
  output logic                     Busy,
  output logic                     Done
);

  localparam int SW = $clog2(DEPTH);

  calc_state_t      state_q;
  calc_state_t      state_d;
  logic [WIDTH-1:0] regs [DEPTH];
  logic [SW-1:0]    sel_q;

  calc_op_t         op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] r;
  logic [WIDTH:0]   sum;
  logic             eq;
  logic [WIDTH-1:0] alu_res;
  logic             alu_flag;

  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  logic             wr_en;
  logic [SW-1:0]    wr_sel;
  logic [WIDTH-1:0] wr_data;
  logic             wr_flag;

  assign op     = calc_op_t'(OpIn);
  assign a      = NumIn;
  assign r      = regs[RegSel];
  assign eq     = (a == r);
  assign NumOut = regs[sel_q];
  assign Busy   = (state_q == MULT);

  always_comb begin
    sum     = {1'b0, a} + {1'b0, r};
    alu_res = a;
    unique case (op)
      OP_ADD:  alu_res = sum[WIDTH-1:0];
      OP_SUB:  alu_res = a - r;
      OP_OR:   alu_res = a | r;
      OP_EQ:   alu_res = {{(WIDTH-1){1'b0}}, eq};
      OP_AND:  alu_res = a & r;
      OP_XOR:  alu_res = a ^ r;
      default: alu_res = a;
    endcase
    unique case (flag_src(op))
      FLG_CARRY:  alu_flag = sum[WIDTH];
      FLG_BORROW: alu_flag = (a < r);
      FLG_EQUAL:  alu_flag = eq;
      default:    alu_flag = 1'b0;
    endcase
  end

  calc_mul_seq #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk    (clk),
    .rst    (rst),
    .ena    (ena),
    .start  (mul_start),
    .a      (a),
    .b      (r),
    .product(mul_prod),
    .done   (mul_done)
  );

  always_comb begin
    state_d   = state_q;
    mul_start = 1'b0;
    wr_en     = 1'b0;
    wr_sel    = RegSel;
    wr_data   = alu_res;
    wr_flag   = alu_flag;
    unique case (state_q)
      IDLE: begin
        if (Enter) begin
          if (op == OP_MUL) begin
            mul_start = 1'b1;
            state_d   = MULT;
          end else begin
            wr_en   = 1'b1;
            state_d = WAIT;
          end
        end
      end
      MULT: begin
        if (mul_done) begin
          wr_en   = 1'b1;
          wr_sel  = sel_q;
          wr_data = mul_prod[WIDTH-1:0];
          wr_flag = |mul_prod[2*WIDTH-1:WIDTH];
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!Enter) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      Flag    <= 1'b0;
      Done    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (ena) begin
      state_q <= state_d;
      Done    <= wr_en;
      if (state_q == IDLE && Enter) begin
        sel_q <= RegSel;
      end
      if (wr_en) begin
        regs[wr_sel] <= wr_data;
        Flag         <= wr_flag;
      end
    end
  end

endmodule

// File: tb/tb_calc_core.sv
// tb_calc_core: randomized bench for calc_core against
// an arithmetic reference model of the accumulator file.
module tb_calc_core;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         ena;
  logic [W-1:0] NumIn;
  logic [2:0]   OpIn;
  logic [1:0]   RegSel;
  logic         Enter;
  logic [W-1:0] NumOut;
  logic         Flag;
  logic         Busy;
  logic         Done;

  int checks = 0;
  int errors = 0;
  int m_regs [D];
  int m_sel;
  int m_flag;

  calc_core #(
    .WIDTH(W),
    .DEPTH(D)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .ena   (ena),
    .NumIn (NumIn),
    .OpIn  (OpIn),
    .RegSel(RegSel),
    .Enter (Enter),
    .NumOut(NumOut),
    .Flag  (Flag),
    .Busy  (Busy),
    .Done  (Done)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic void calc(
    input  int op,
    input  int a,
    input  int r,
    output int res,
    output int f
  );
    int t;
    f = 0;
    case (op)
      0: begin t = a + r; res = t % 256; f = (t > 255) ? 1 : 0; end
      1: begin res = (a - r + 256) % 256; f = (a < r) ? 1 : 0; end
      2: res = a | r;
      3: begin res = (a == r) ? 1 : 0; f = res; end
      4: res = a & r;
      5: res = a ^ r;
      6: begin t = a * r; res = t % 256; f = (t > 255) ? 1 : 0; end
      default: res = a;
    endcase
  endfunction

  task automatic run_cmd(
    input int op,
    input int a,
    input int sel,
    input int hold,
    input int gap,
    input int gap_at
  );
    int lat;
    int res;
    int f;
    calc(op, a, m_regs[sel], res, f);
    lat = (op == 6) ? W + 1 : 1;
    @(negedge clk);
    NumIn  = W'(a);
    OpIn   = 3'(op);
    RegSel = 2'(sel);
    Enter  = 1'b1;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (c < lat) begin
        check("busy", 32'(Busy), 1);
        check("done_early", 32'(Done), 0);
        check("out_during_mul", 32'(NumOut), m_regs[sel]);
        check("flag_during_mul", 32'(Flag), m_flag);
        Enter  = 1'($urandom_range(0, 1));
        NumIn  = W'($urandom);
        OpIn   = 3'($urandom);
        RegSel = 2'($urandom);
      end else begin
        m_regs[sel] = res;
        m_sel       = sel;
        m_flag      = f;
        check("done", 32'(Done), 1);
        check("busy_end", 32'(Busy), 0);
        check("result", 32'(NumOut), res);
        check("flag", 32'(Flag), f);
      end
      if (gap > 0 && c == gap_at) begin
        ena = 1'b0;
        repeat (gap) begin
          @(negedge clk);
          check("frz_busy", 32'(Busy), (c < lat) ? 1 : 0);
          check("frz_done", 32'(Done), (c == lat) ? 1 : 0);
          check("frz_out", 32'(NumOut), m_regs[sel]);
          check("frz_flag", 32'(Flag), m_flag);
        end
        ena = 1'b1;
      end
    end
    Enter = (hold > 0) ? 1'b1 : 1'b0;
    repeat (hold) begin
      @(negedge clk);
      check("one_pulse", 32'(Done), 0);
      check("wait_out", 32'(NumOut), m_regs[m_sel]);
    end
    Enter  = 1'b0;
    RegSel = 2'($urandom);
    @(negedge clk);
    check("idle_done", 32'(Done), 0);
    check("idle_out", 32'(NumOut), m_regs[m_sel]);
  endtask

  task automatic reset_mid_mul();
    @(negedge clk);
    NumIn  = W'(77);
    OpIn   = 3'(6);
    RegSel = 2'(3);
    Enter  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_pre_busy", 32'(Busy), 1);
    rst   = 1'b1;
    Enter = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < D; i++) m_regs[i] = 0;
    m_sel  = 0;
    m_flag = 0;
    check("rst_out", 32'(NumOut), 0);
    check("rst_flag", 32'(Flag), 0);
    check("rst_busy", 32'(Busy), 0);
    check("rst_done", 32'(Done), 0);
    repeat (W + 2) begin
      @(negedge clk);
      check("rst_no_write", 32'(Done), 0);
    end
  endtask

  initial begin
    int op;
    int lat;
    int gap;
    rst    = 1'b1;
    ena    = 1'b1;
    Enter  = 1'b0;
    NumIn  = '0;
    OpIn   = '0;
    RegSel = '0;
    for (int i = 0; i < D; i++) m_regs[i] = 0;
    m_sel  = 0;
    m_flag = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_out", 32'(NumOut), 0);
    check("reset_flag", 32'(Flag), 0);
    check("reset_busy", 32'(Busy), 0);
    check("reset_done", 32'(Done), 0);

    run_cmd(0, 5, 0, 2, 0, 0);
    run_cmd(0, 5, 0, 0, 0, 0);
    run_cmd(7, 200, 0, 0, 0, 0);
    run_cmd(0, 100, 0, 0, 0, 0);
    run_cmd(3, 44, 0, 0, 0, 0);
    run_cmd(7, 10, 1, 0, 0, 0);
    run_cmd(1, 3, 1, 0, 0, 0);
    run_cmd(7, 9, 0, 1, 0, 0);
    run_cmd(2, 0, 1, 0, 0, 0);
    run_cmd(7, 13, 2, 0, 0, 0);
    run_cmd(6, 20, 2, 1, 0, 0);
    run_cmd(6, 255, 2, 0, 5, 3);
    run_cmd(5, 170, 3, 0, 2, 1);

    reset_mid_mul();
    for (int i = 0; i < D; i++) run_cmd(2, 0, i, 0, 0, 0);

    for (int n = 0; n < 80; n++) begin
      op  = $urandom_range(0, 7);
      lat = (op == 6) ? W + 1 : 1;
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      run_cmd(op, $urandom_range(0, 255), $urandom_range(0, D - 1),
              $urandom_range(0, 2), gap, $urandom_range(1, lat));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_core.md
# calc_core

Parametrised accumulator calculator: a `DEPTH`-entry register file of `WIDTH`-bit accumulators updated by an 8-operation ALU. Single-cycle logic and compare ops; a multi-cycle shift-add multiply. Same `Enter` press/release handshake as the existing 8-bit calculator, plus register select, `Busy`/`Done` status and a `Flag` output. Sits between the pad-level input synchroniser and the output mux in the calculator top level.

## Interface
- `WIDTH`, default 8: operand/accumulator width, ≥2.
- `DEPTH`, default 4: number of accumulators, power of two ≥2.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `ena`  in  1  clock enable; low freezes every register.
- `NumIn`  in  WIDTH  operand.
- `OpIn`  in  3  opcode (`calc_op_t`).
- `RegSel`  in  $clog2(DEPTH)  accumulator index.
- `Enter`  in  1  command strobe, level; one command per press.
- `NumOut`  out  WIDTH  value of accumulator `sel_q`.
- `Flag`  out  1  status of last completed op.
- `Busy`  out  1  multiply in progress.
- `Done`  out  1  one-cycle pulse when a result is written.

## Operation
- Opcodes, with A = `NumIn` and R = `regs[RegSel]`, result to `regs[RegSel]`:
  - 000 ADD: A+R; Flag = carry out.
  - 001 SUB: A−R; Flag = borrow (A<R).
  - 010 OR: A|R; Flag = 0.
  - 011 EQ: result 1 if A==R, else 0; Flag = same bit.
  - 100 AND: A&R; Flag = 0.
  - 101 XOR: A^R; Flag = 0.
  - 110 MUL: low WIDTH bits of A*R; Flag = high half nonzero.
  - 111 LOAD: A; Flag = 0.
- All arithmetic is unsigned, modulo 2^WIDTH.
- FSM states (`calc_state_t`):
  - IDLE: accepts `Enter`=1 with `ena`=1. Latches `RegSel`→`sel_q`, `OpIn`, A and R.
    - Non-MUL: writes the result and Flag at the same edge, then goes to WAIT.
    - MUL: goes to MULT.
  - MULT: one multiplier step per enabled cycle for WIDTH cycles. Then writes the result and Flag and goes to WAIT.
  - WAIT: stays while `Enter`=1; goes to IDLE on the first enabled cycle with `Enter`=0. No command is accepted in this state.
- `Enter` in MULT or WAIT is ignored. Holding `Enter` through a multiply does not queue a second command.
- `NumIn`, `OpIn` and `RegSel` are sampled only at accept. Later changes have no effect on the running op.
- `NumOut` always shows `regs[sel_q]`. Changing `RegSel` while idle does not change `NumOut` until the next accept.
- `ena`=0 holds the state, all accumulators, multiplier progress, Flag, and an asserted `Done`.
- Reset values: all accumulators 0, `sel_q`=0, state IDLE. Outputs `NumOut`=0, `Flag`=0, `Busy`=0, `Done`=0.
- Reset mid-multiply aborts the op with no write; the above reset values apply.

## Timing
- Single-cycle op accepted at edge N:
  - `NumOut` and `Flag` are updated after edge N.
  - `Done`=1 for the cycle after edge N.
- MUL accepted at edge N:
  - `Busy`=1 after edge N through edge N+WIDTH.
  - The result is written at edge N+WIDTH.
  - `Done`=1 for the cycle after edge N+WIDTH; `Busy` falls at the same edge.
- `Done` is registered and never high for 2 consecutive enabled cycles.
- Minimum spacing between accepts: 2 enabled cycles (accept, WAIT with `Enter`=0).
- `Enter` must drop for one enabled cycle before the next press is accepted.

## Structure
- `calc_pkg` holds:
  - `calc_op_t`, the 3-bit opcode enum.
  - `calc_state_t` {IDLE, MULT, WAIT}.
  - Flag-source constants.
- Sub-module `calc_mul_seq`: WIDTH-cycle shift-add multiplier.
  - Inputs: `start`, A, B, `ena`.
  - Outputs: 2·WIDTH product and a `done` strobe.
  - Instantiated once. Shares `clk` and `rst`.
- Top holds the FSM, the register file, the single-cycle ALU and the `Done`/`Flag` registers.

## Test plan
All scenarios use WIDTH=8, DEPTH=4.
- Reset, then ADD with `NumIn`=5, `RegSel`=0, `Enter` held 3 cycles → `NumOut`=5, `Flag`=0, exactly one `Done` pulse; the second press adds again to give 10.
- LOAD 200 into reg0, then ADD 100 → `NumOut`=44, `Flag`=1. EQ with `NumIn`=44 → `NumOut`=1, `Flag`=1.
- LOAD 10 into reg1, then SUB with `NumIn`=3 → 249, `Flag`=1. Select reg0 with a LOAD → `NumOut` shows reg0; reg1 stays 249.
- LOAD 13 into reg2, then MUL with `NumIn`=20 → `Busy` high 8 cycles, `NumOut`=4, `Flag`=1, `Done` on cycle 9. `Enter` toggles during `Busy` are ignored.
- Start MUL, drop `ena` for 5 cycles mid-multiply → completion delayed exactly 5 cycles, same result.
- Start MUL, assert `rst` at cycle 3 → all outputs 0, accumulators 0, next command accepted normally.
